// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexes four hex nibbles onto a 4-digit 7-segment display,
// committing new words only at frame boundaries and blanking anodes for one cycle per slot.
module seg7_scan_driver #(
    parameter int DIGIT_CYCLES = 50000,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] display_in,
    input  logic        load,
    input  logic [3:0]  blank_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_done,
    output logic        load_ack
);
    localparam int CW = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   shadow_q, shadow_d, active_q, active_d;
    logic          pending_q, pending_d, ack_q, ack_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d, hex;
    logic [1:0]    idx;
    logic          slot_start, slot_end;
    always_comb begin
        idx        = state_q;
        slot_start = cnt_q == '0;
        slot_end   = cnt_q == CW'(DIGIT_CYCLES - 1);
        frame_done = (state_q == DIG3) && slot_end;
        cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
        state_d    = slot_end ? state_t'(state_q + 2'd1) : state_q;
        hex        = HEX[active_q[{idx, 2'b00} +: 4]];
        // count 0 of each slot is the anti-ghosting guard; the new digit's segments settle here
        an_d       = (slot_start || blank_mask[idx]) ? AN_OFF
                   : (ACTIVE_LOW ? ~(4'b0001 << idx) : (4'b0001 << idx));
        seg_d      = slot_start ? (ACTIVE_LOW ? ~hex : hex) : seg_q;
        shadow_d   = load ? display_in : shadow_q;
        active_d   = !frame_done ? active_q : load ? display_in : pending_q ? shadow_q : active_q;
        pending_d  = !frame_done && (load || pending_q);
        ack_d      = frame_done && (load || pending_q);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DIG0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            an_q      <= AN_OFF;
            seg_q     <= SEG_OFF;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end
    assign an       = an_q;
    assign seg      = seg_q;
    assign load_ack = ack_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized and directed checks of seg7_scan_driver against a cycle-index model.
module tb_seg7_scan_driver;
    localparam int DC = 4;
    localparam int FR = 4 * DC;
    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic        clk = 1'b0, rst = 1'b0, load = 1'b0;
    logic [15:0] display_in = '0;
    logic [3:0]  blank_mask = '0, an;
    logic [6:0]  seg;
    logic        frame_done, load_ack;
    int          n_chk = 0, n_fail = 0, k = 0;
    logic [15:0] m_active, m_shadow;
    logic        m_pending, m_ack;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;
    seg7_scan_driver #(.DIGIT_CYCLES(DC), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .display_in(display_in), .load(load), .blank_mask(blank_mask),
        .an(an), .seg(seg), .frame_done(frame_done), .load_ack(load_ack)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h expected %h", tag, k, got, exp);
        end
    endtask
    task automatic model_reset();
        k = 0; m_active = '0; m_shadow = '0; m_pending = 1'b0; m_ack = 1'b0;
        m_an = 4'hF; m_seg = 7'h7F;
    endtask
    // model derives slot position purely from the edge count since reset release
    task automatic model_edge(input logic ld, input logic [15:0] d, input logic [3:0] m);
        int c, i;
        logic bnd;
        c = k % DC; i = (k / DC) % 4; bnd = (k % FR) == FR - 1;
        m_an = (c == 0 || m[i]) ? 4'hF : ~(4'b0001 << i);
        if (c == 0) m_seg = ~HEX[m_active[4*i +: 4]];
        m_ack = bnd && (ld || m_pending);
        if (bnd) begin
            if (ld) m_active = d;
            else if (m_pending) m_active = m_shadow;
            m_pending = 1'b0;
        end else if (ld) begin
            m_shadow = d; m_pending = 1'b1;
        end
    endtask
    task automatic cyc(input logic ld, input logic [15:0] d, input logic [3:0] m);
        load = ld; display_in = d; blank_mask = m;
        check("frame_done", frame_done, (k % FR) == FR - 1);
        @(posedge clk);
        model_edge(ld, d, m);
        k++;
        @(negedge clk);
        check("an", an, m_an);
        check("seg", seg, m_seg);
        check("load_ack", load_ack, m_ack);
        check("an_onehot", $countones(~an) <= 1, 1);
    endtask
    task automatic idle(input int n, input logic [3:0] m);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, m);
    endtask
    task automatic to_edge(input int pos);
        while ((k % FR) != pos) cyc(1'b0, 16'h0, 4'h0);
    endtask
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_ack", load_ack, 0);
        check("rst_fd", frame_done, 0);
        load = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hold_an", an, 4'hF);
        check("rst_hold_ack", load_ack, 0);
        rst = 1'b1;
        model_reset();
    endtask
    initial begin
        model_reset();
        @(negedge clk);
        check("init_an", an, 4'hF);
        check("init_seg", seg, 7'h7F);
        check("init_ack", load_ack, 0);
        check("init_fd", frame_done, 0);
        rst = 1'b1;
        cyc(1'b0, 16'h0, 4'h0);
        check("guard_slot0", an, 4'hF);
        cyc(1'b0, 16'h0, 4'h0);
        check("first_an0", an, 4'hE);
        cyc(1'b1, 16'h1234, 4'h0);
        idle(2 * FR, 4'h0);
        to_edge(2);
        cyc(1'b1, 16'hAAAA, 4'h0);
        idle(3, 4'h0);
        cyc(1'b1, 16'hBEEF, 4'h0);
        idle(2 * FR, 4'h0);
        to_edge(FR - 1);
        cyc(1'b1, 16'h00FF, 4'h0);
        check("bypass_ack", load_ack, 1);
        idle(FR, 4'h0);
        idle(2 * FR, 4'b0101);
        to_edge(9);
        cyc(1'b1, 16'h5A5A, 4'h0);
        do_reset();
        idle(3 * FR, 4'h0);
        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(0, 7) == 0, 16'($urandom),
                ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
        to_edge(6);
        do_reset();
        idle(2 * FR, 4'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
